seg_owner_arb: RTL and testbench
================================

Name: seg_owner_arb

Overview:
- Shares the board's four 8-bit active-low segment outputs (BCD, BCD1, BCD2, BCD3) between NREQ pattern-generator requesters.
- Grants one requester at a time, round-robin, for a bounded number of slow ticks.
- The owner's pattern is written into the digit it targets.
- The push-buttons pin a preferred requester, which then preempts the round-robin.
- Sits between the pattern generators and the board display pins.

Parameters:
- NREQ, 4, number of requesters (2..8; bench uses 4).
- TICK_W, 24, prescaler width; one tick every 2^TICK_W CLK cycles.
- HOLD, 4, ticks a grant lasts before forced release (>=1).

Ports:
- CLK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  4  raw push-buttons, active-low; 4'b1111 = none pressed.
- req  in  NREQ  request per requester, level, active-high.
- pat  in  8*NREQ  pattern per requester, active-high segments; requester i uses bits [8i+7:8i].
- dig  in  2*NREQ  target digit per requester (0..3); requester i uses bits [2i+1:2i].
- gnt  out  NREQ  one-hot grant, registered.
- tick  out  1  one-cycle prescaler pulse, registered.
- BCD, BCD1, BCD2, BCD3  out  8 each  digit 0..3 segment drive, active-low, registered.

Behaviour:
- Reset (async, rst_n low):
  - gnt=0, tick=0, all BCDn=8'hFF (blank).
  - Prescaler=0, state=IDLE, rr_last=NREQ-1, pin_valid=0, pin=0, hold_cnt=0, button sync flops=4'b1111.
- Prescaler: free-running TICK_W-bit counter. tick=1 for exactly the cycle after the counter holds all-ones, then returns to 0.
- Buttons:
  - 2-flop synchronizer on btn.
  - When the synced value != 4'b1111: pin <= index of the lowest-numbered low bit, pin_valid <= 1.
  - All-released leaves pin and pin_valid unchanged (sticky).
  - Indices >= NREQ are ignored.
- Eligibility: requester i is eligible when req[i]=1.
- Pick:
  - If pin_valid and req[pin], pick pin.
  - Otherwise pick the first eligible requester searching rr_last+1, rr_last+2, ... with wrap modulo NREQ.
- FSM states: IDLE, GRANT.
  - IDLE, when any requester is eligible: owner <= pick, gnt <= one-hot(owner), rr_last <= owner, hold_cnt <= HOLD-1, go to GRANT.
  - IDLE, with no requester eligible: stay in IDLE with gnt=0.
  - GRANT, on each tick: if hold_cnt==0, release; otherwise decrement hold_cnt.
  - GRANT, release also occurs if req[owner]=0.
  - GRANT, release also occurs if pin_valid, pin!=owner and req[pin]=1 (preemption).
  - Release means: gnt <= 0, go to IDLE. Re-arbitration happens on the following cycle, so there is a 1-cycle gap with gnt=0 between owners.
  - When multiple release causes occur in the same cycle, a single release results.
- Digit write:
  - Every cycle in GRANT that is not a release cycle, digit dig[owner] <= ~pat[owner].
  - Other digits hold their last value; digits are never auto-blanked.
- Latency:
  - req rising while in IDLE gives gnt high after 1 edge.
  - The corresponding BCDn is updated 1 edge after gnt.
  - Pattern or target changes while granted show 1 edge later.
- Grant length: a grant starting mid-prescaler period lasts from HOLD-1 full tick periods plus a partial period, up to HOLD full tick periods.
- Width rules:
  - The round-robin index is clog2(NREQ) bits and wraps modulo NREQ (not power-of-two safe for the bench's NREQ=4 only; implementation must wrap explicitly).
  - dig values are 0..3 always valid.
- Reset mid-grant: immediate return to reset values; no partial writes survive.

Decomposition:
- Package seg_arb_pkg:
  - state enum {IDLE, GRANT}
  - NDIG=4
  - BLANK=8'hFF
  - BTN_IDLE=4'b1111
- Sub-module rr_pick: purely combinational. Inputs are req, rr_last, pin, pin_valid; outputs are the picked index and an any-eligible flag. It is reused by other display arbiters.

Test Plan:
- Bench settings for all scenarios: TICK_W=2, HOLD=2.
- Reset: rst_n low mid-operation -> BCD..BCD3=8'hFF, gnt=0 immediately; after release, rr_last=3 so req=4'b1111 grants requester 0 first.
- Round-robin: req=4'b1111, constant, pat_i=8'h01<<i, dig_i=i -> grant order 0,1,2,3,0 with a 1-cycle gap between owners; each grant ends on its second tick; BCDi=~(8'h01<<i).
- Request drop: requester 2 alone, dig=3, pat=8'h3C; drop req after 3 cycles -> gnt=0 next edge; BCD3 stays 8'hC3.
- Button pin/preempt:
  - Requester 1 granted, req=4'b0011.
  - Drive btn=4'b1110 for 3 cycles -> after sync, requester 1 is released and requester 0 granted.
  - Release the buttons -> requester 0 keeps winning every re-arbitration while req[0]=1.
- Live update: owner changes pat 8'hAA->8'h55 mid-grant and dig 0->2 -> BCD=8'h55 then BCD2=8'hAA one edge after each change; the older digit keeps its last value.
- Simultaneous: req[owner] falls on the same cycle as tick with hold_cnt==0 -> single release, no digit write that cycle, next owner granted on the following edge.

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the segment-display owner arbiters.
package seg_arb_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam int          NDIG     = 4;
    localparam logic [7:0]  BLANK    = 8'hFF;
    localparam logic [3:0]  BTN_IDLE = 4'b1111;
endpackage

// File: rtl/rr_pick.sv
// Combinational owner picker: a pinned requester wins if it is asking,
// otherwise round-robin starting just after the last owner.
module rr_pick
    import seg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_last,
    input  logic [IW-1:0]   pin,
    input  logic            pin_valid,
    output logic [IW-1:0]   pick,
    output logic            any
);
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] cand;
    logic          found;

    // Explicit modulo so non-power-of-two NREQ wraps correctly.
    always_comb begin
        rr_idx = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_last) + k) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                rr_idx = cand;
            end
        end
    end

    assign any  = |req;
    assign pick = (pin_valid && req[pin]) ? pin : rr_idx;
endmodule

// File: rtl/seg_owner_arb.sv
// Time-shares the four active-low segment digits between NREQ pattern
// generators: round-robin grants bounded in ticks, button-pinned preemption.
module seg_owner_arb
    import seg_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int TICK_W = 24,
    parameter int HOLD   = 4
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [3:0]        btn,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] pat,
    input  logic [2*NREQ-1:0] dig,
    output logic [NREQ-1:0]   gnt,
    output logic              tick,
    output logic [7:0]        BCD,
    output logic [7:0]        BCD1,
    output logic [7:0]        BCD2,
    output logic [7:0]        BCD3
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [TICK_W-1:0]          presc;
    logic [3:0]                 btn_s1, btn_s2;
    logic [IW-1:0]              pin, btn_idx;
    logic                       pin_valid, btn_hit;
    state_t                     state;
    logic [IW-1:0]              owner, rr_last, pick;
    logic                       any;
    logic [HW-1:0]              hold_cnt;
    logic [NDIG-1:0][7:0]       seg;
    logic [NREQ-1:0][7:0]       pat_v;
    logic [NREQ-1:0][1:0]       dig_v;
    logic                       preempt, release_now;

    assign pat_v = pat;
    assign dig_v = dig;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc + TICK_W'(1);
            tick  <= &presc;
        end
    end

    // Lowest pressed button that names a real requester; others are ignored.
    always_comb begin
        btn_hit = 1'b0;
        btn_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!btn_s2[i] && i < NREQ) begin
                btn_hit = 1'b1;
                btn_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1    <= BTN_IDLE;
            btn_s2    <= BTN_IDLE;
            pin       <= '0;
            pin_valid <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            if (btn_hit) begin
                pin       <= btn_idx;
                pin_valid <= 1'b1;
            end
        end
    end

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req       (req),
        .rr_last   (rr_last),
        .pin       (pin),
        .pin_valid (pin_valid),
        .pick      (pick),
        .any       (any)
    );

    assign preempt     = pin_valid && (pin != owner) && req[pin];
    assign release_now = (tick && hold_cnt == '0) || !req[owner] || preempt;

    // Release always drops to IDLE, giving a one-cycle gnt=0 gap between owners.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_last  <= IW'(NREQ-1);
            hold_cnt <= '0;
            seg      <= {NDIG{BLANK}};
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (any) begin
                        owner    <= pick;
                        gnt      <= NREQ'(1) << pick;
                        rr_last  <= pick;
                        hold_cnt <= HW'(HOLD-1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end else begin
                        if (tick)
                            hold_cnt <= hold_cnt - HW'(1);
                        seg[dig_v[owner]] <= ~pat_v[owner];
                    end
                end
            endcase
        end
    end

    assign BCD  = seg[0];
    assign BCD1 = seg[1];
    assign BCD2 = seg[2];
    assign BCD3 = seg[3];
endmodule

// File: tb/tb_seg_owner_arb.sv
// Bench for seg_owner_arb: directed scenarios plus random traffic, all outputs
// checked every cycle against a behavioural owner/queue model.
module tb_seg_owner_arb;
    localparam int NREQ = 4, TICK_W = 2, HOLD = 2;

    logic              CLK = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        btn = 4'hF;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] pat = '0;
    logic [2*NREQ-1:0] dig = '0;
    logic [NREQ-1:0]   gnt;
    logic              tick;
    logic [7:0]        BCD, BCD1, BCD2, BCD3;

    seg_owner_arb #(.NREQ(NREQ), .TICK_W(TICK_W), .HOLD(HOLD)) dut (
        .CLK(CLK), .rst_n(rst_n), .btn(btn), .req(req), .pat(pat), .dig(dig),
        .gnt(gnt), .tick(tick), .BCD(BCD), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = none), ticks consumed by the current
    // grant, digit contents as one 32-bit word, tick from edge count since reset.
    int          m_owner, m_rr, m_pin, m_ticks, m_n;
    bit          m_pinv, m_tick;
    logic [31:0] m_seg;
    logic [3:0]  m_b1, m_b2;

    function automatic bit rq(logic [NREQ-1:0] r, int i);
        return ((r >> i) & 1) != 0;
    endfunction

    function automatic int m_pick(logic [NREQ-1:0] r);
        if (m_pinv && rq(r, m_pin)) return m_pin;
        for (int k = 1; k <= NREQ; k++)
            if (rq(r, (m_rr + k) % NREQ)) return (m_rr + k) % NREQ;
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1; m_rr = NREQ - 1; m_pin = 0; m_pinv = 0; m_ticks = 0;
        m_n = 0; m_tick = 0; m_seg = 32'hFFFF_FFFF; m_b1 = 4'hF; m_b2 = 4'hF;
    endtask

    task automatic m_step();
        bit         rel, got;
        int         d;
        logic [7:0] p;
        if (m_owner < 0) begin
            if (req != '0) begin
                m_owner = m_pick(req);
                m_rr    = m_owner;
                m_ticks = 0;
            end
        end else begin
            rel = !rq(req, m_owner) || (m_pinv && m_pin != m_owner && rq(req, m_pin))
                  || (m_tick && m_ticks + 1 >= HOLD);
            if (rel) m_owner = -1;
            else begin
                if (m_tick) m_ticks++;
                p = 8'(pat >> (8 * m_owner));
                d = int'(2'(dig >> (2 * m_owner)));
                m_seg = (m_seg & ~(32'hFF << (8 * d))) | ({24'h0, ~p} << (8 * d));
            end
        end
        got = 0;
        for (int i = 0; i < 4; i++)
            if (!got && !m_b2[i] && i < NREQ) begin got = 1; m_pin = i; m_pinv = 1; end
        m_b2 = m_b1;
        m_b1 = btn;
        m_n++;
        m_tick = (m_n % (1 << TICK_W)) == 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("gnt",  gnt,  (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
            chk("tick", tick, m_tick);
            chk("BCD",  BCD,  m_seg[7:0]);
            chk("BCD1", BCD1, m_seg[15:8]);
            chk("BCD2", BCD2, m_seg[23:16]);
            chk("BCD3", BCD3, m_seg[31:24]);
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        rst_n = 0; req = '0; pat = '0; dig = '0; btn = 4'hF;
        repeat (2) @(posedge CLK);
        #1 rst_n = 1;
    endtask

    task automatic wait_gnt(string nm, logic [NREQ-1:0] e, int maxc);
        for (int i = 0; i < maxc && gnt !== e; i++) begin @(posedge CLK); #1; end
        chk(nm, gnt, e);
    endtask

    logic [3:0] rr_exp [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] seen [$];
    logic [3:0] prevg;
    int direct_sw, bad_own, tk;

    initial begin
        chk_en = 1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_bcd", {BCD, BCD1, BCD2, BCD3}, 32'hFFFF_FFFF);
        rst_n = 1;

        // Round-robin over all four requesters.
        req = 4'hF; pat = 32'h0804_0201; dig = 8'b11_10_01_00;
        prevg = '0; direct_sw = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge CLK); #1;
            if (gnt != 0 && prevg != 0 && gnt != prevg) direct_sw++;
            if (gnt != 0 && gnt != prevg) seen.push_back(gnt);
            prevg = gnt;
        end
        for (int i = 0; i < 5; i++) chk("rr_order", (i < seen.size()) ? seen[i] : 4'h0, rr_exp[i]);
        chk("rr_gap", direct_sw, 0);
        chk("rr_bcd", {BCD3, BCD2, BCD1, BCD}, 32'hF7FB_FDFE);

        // Async reset mid-operation, then requester 0 wins first.
        @(negedge CLK); #2 rst_n = 0;
        #1;
        chk("rst_mid_gnt", gnt, 0);
        chk("rst_mid_bcd", {BCD, BCD1, BCD2, BCD3}, 32'hFFFF_FFFF);
        @(posedge CLK); #1 rst_n = 1;
        @(posedge CLK); #1;
        chk("rst_first", gnt, 4'h1);

        // Request drop.
        do_reset();
        req = 4'b0100; pat = 32'h003C_0000; dig = 8'b00_11_00_00;
        @(posedge CLK); #1;
        chk("drop_gnt", gnt, 4'b0100);
        repeat (3) @(posedge CLK);
        #1;
        chk("drop_bcd3", BCD3, 8'hC3);
        req = '0;
        @(posedge CLK); #1;
        chk("drop_rel", gnt, 0);
        @(posedge CLK); #1;
        chk("drop_keep", BCD3, 8'hC3);

        // Button pin and preemption.
        do_reset();
        req = 4'b0010; pat = 32'h0000_5A33; dig = 8'b00_00_01_00;
        @(posedge CLK); #1;
        chk("pin_own1", gnt, 4'b0010);
        req = 4'b0011; btn = 4'b1110;
        repeat (3) @(posedge CLK);
        #1 btn = 4'hF;
        wait_gnt("pin_preempt", 4'b0001, 10);
        bad_own = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (gnt == 4'b0010) bad_own++;
        end
        chk("pin_sticky", bad_own, 0);

        // Live pattern/target update while granted.
        do_reset();
        req = 4'b0001; pat = 32'h0000_00AA; dig = 8'b00_00_00_00;
        repeat (2) @(posedge CLK);
        #1;
        chk("live_bcd0", BCD, 8'h55);
        pat = 32'h0000_0055; dig = 8'b00_00_00_10;
        repeat (4) @(posedge CLK);
        #1;
        chk("live_bcd2", BCD2, 8'hAA);
        chk("live_old", BCD, 8'h55);

        // req[owner] falls together with the hold-expiry tick.
        do_reset();
        req = 4'b0011; pat = 32'h0000_2211; dig = 8'b00_00_01_00;
        wait_gnt("sim_own0", 4'b0001, 4);
        tk = 0;
        for (int c = 0; c < 20 && tk < 2; c++) begin
            if (tick && gnt == 4'b0001) tk++;
            if (tk < 2) begin @(posedge CLK); #1; end
        end
        chk("sim_found", tk, 2);
        req = 4'b0010; pat = 32'h0000_2277;
        @(posedge CLK); #1;
        chk("sim_rel", gnt, 0);
        chk("sim_nowrite", BCD, 8'hEE);
        @(posedge CLK); #1;
        chk("sim_next", gnt, 4'b0010);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) pat = 32'($urandom);
            if ($urandom_range(0, 5) == 0) dig = 8'($urandom);
            btn = ($urandom_range(0, 60) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 500) == 0) begin rst_n = 0; #2 rst_n = 1; end
        end

        @(posedge CLK); #1;
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
